// File: rtl/conv_acc_writeback.sv
// conv_acc_writeback
//   Sits after the 32-bit ALU in the convolution datapath. Sums TAPS signed
//   tap products per output pixel, applies a rounded arithmetic right shift,
//   clamps the result to an 8-bit pixel and writes it to the output image
//   memory over a req/ack handshake with an auto-incrementing address.
//   Build option: define CONV_ABS_MODE_EN to take the magnitude of a negative
//   shifted sum before clamping (edge responses kept as magnitudes); when it
//   is undefined, negative sums clamp to 0.
module conv_acc_writeback #(
   parameter int TAPS       = 9,
   parameter int SHIFT      = 4,
   parameter int ACC_W      = 40,
   parameter int NUM_PIXELS = 16384,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              alu_valid,
   input  logic [31:0]       C_bus,
   output logic              alu_ready,
   output logic              mem_wr_req,
   input  logic              mem_wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              Z_flag,
   output logic              frame_done
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS + 1) : 1;
   // Half an LSB of the shifted result; zero when no shift is applied.
   localparam logic [ACC_W-1:0]  ROUND     = ACC_W'((64'd1 << SHIFT) >> 1);
   localparam logic [CNT_W-1:0]  LAST_TAP  = CNT_W'(TAPS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      NORM  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                z_q, z_d;
   logic                req_q, req_d;
   logic                done_q, done_d;

   logic [ACC_W-1:0]        tap_ext;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] mag;
   logic [7:0]              pixel;

   // Normalize the running sum: round, arithmetic shift, optional magnitude, clamp to 0..255.
   always_comb begin
      tap_ext = ACC_W'($signed(C_bus));
      shifted = $signed(acc_q + ROUND) >>> SHIFT;
      mag     = shifted;
`ifdef CONV_ABS_MODE_EN
      if (shifted[ACC_W-1]) begin
         mag = -shifted;
      end
`endif
      if (mag[ACC_W-1]) begin
         pixel = 8'd0;
      end else if (|mag[ACC_W-2:8]) begin
         pixel = 8'hFF;
      end else begin
         pixel = mag[7:0];
      end
   end

   // Next-state and datapath update; frame_start overrides everything but reset.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      z_d     = z_q;
      req_d   = req_q;
      done_d  = 1'b0;

      case (state_q)
         ACCUM: begin
            // alu_ready is high throughout ACCUM, so alu_valid alone marks a transfer.
            if (alu_valid) begin
               acc_d = acc_q + tap_ext;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_TAP) begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            wdata_d = pixel;
            z_d     = (pixel == 8'd0);
            acc_d   = '0;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            if (mem_wr_ack) begin
               req_d   = 1'b0;
               state_d = ACCUM;
               if (addr_q == LAST_ADDR) begin
                  addr_d = '0;
                  done_d = 1'b1;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase

      // Restart the frame: abandon any pending write and drop any tap offered this cycle.
      if (frame_start) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         addr_d  = '0;
         req_d   = 1'b0;
         done_d  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         z_q     <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         z_q     <= z_d;
         req_q   <= req_d;
         done_q  <= done_d;
      end
   end

   assign alu_ready  = (state_q == ACCUM);
   assign mem_wr_req = req_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign Z_flag     = z_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_conv_acc_writeback.sv
// Self-checking bench for conv_acc_writeback (TAPS=9, SHIFT=4, NUM_PIXELS=4).
// Expected pixels are computed from the tap values and queued when the taps
// are driven, then popped and compared when the write request appears.
module tb_conv_acc_writeback;
   localparam int TAPS       = 9;
   localparam int SHIFT      = 4;
   localparam int ACC_W      = 40;
   localparam int NUM_PIXELS = 4;
   localparam int ADDR_W     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_start;
   logic              alu_valid;
   logic [31:0]       C_bus;
   logic              alu_ready;
   logic              mem_wr_req;
   logic              mem_wr_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              Z_flag;
   logic              frame_done;

   conv_acc_writeback #(
      .TAPS(TAPS), .SHIFT(SHIFT), .ACC_W(ACC_W), .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .alu_valid(alu_valid),
      .C_bus(C_bus), .alu_ready(alu_ready), .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .Z_flag(Z_flag), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              z;
      logic              last;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] tap_vals [TAPS];
   int          model_addr = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference pixel from the current tap table.
   function automatic logic [7:0] model_pixel();
      longint sum = 0;
      longint s;
      longint rnd;
      for (int i = 0; i < TAPS; i++) sum += longint'($signed(tap_vals[i]));
      rnd = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
      s = (sum + rnd) >>> SHIFT;
`ifdef CONV_ABS_MODE_EN
      if (s < 0) s = -s;
`endif
      if (s < 0) return 8'd0;
      if (s > 255) return 8'hFF;
      return 8'(s);
   endfunction

   task automatic push_expected();
      exp_t e;
      e.data = model_pixel();
      e.addr = ADDR_W'(model_addr);
      e.z    = (e.data == 8'd0);
      e.last = (model_addr == NUM_PIXELS - 1);
      exp_q.push_back(e);
      model_addr = e.last ? 0 : model_addr + 1;
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int i = 0; i < TAPS; i++) tap_vals[i] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < TAPS; i++) tap_vals[i] = 32'($signed(int'($urandom_range(0, 600)) - 300));
   endtask

   task automatic drive_taps(input int n);
      for (int i = 0; i < n; i++) begin
         C_bus     = tap_vals[i];
         alu_valid = 1'b1;
         step();
      end
      alu_valid = 1'b0;
      C_bus     = 32'h0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (mem_wr_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      ok = (exp_q.size() != 0);
      if (ok) e = exp_q.pop_front();
      else begin
         e.addr = '0; e.data = '0; e.z = 1'b0; e.last = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; frame_start = 1'b0; alu_valid = 1'b0; mem_wr_ack = 1'b0; C_bus = 32'h0;
      step();
      step();
      checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready actual=%b required=1", alu_ready); end
      checks++; if (mem_wr_req !== 1'b0) begin failures++; $display("FAIL reset_req actual=%b required=0", mem_wr_req); end
      checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr actual=%0d required=0", mem_addr); end
      checks++; if (mem_wdata !== 8'h00 || Z_flag !== 1'b0) begin failures++; $display("FAIL reset_data actual=%h/%b required=00/0", mem_wdata, Z_flag); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done actual=%b required=0", frame_done); end
      reset = 1'b0;
      exp_q.delete();
      model_addr = 0;
      $display("txn reset done");
   endtask

   task automatic test_basic();
      exp_t e;
      bit ok;
      fill_const(32'd16);
      push_expected();
      drive_taps(TAPS);
      checks++; if (mem_wr_req !== 1'b0) begin failures++; $display("FAIL basic_norm_req actual=%b required=0", mem_wr_req); end
      step();
      checks++; if (mem_wr_req !== 1'b1) begin failures++; $display("FAIL basic_latency_req actual=%b required=1", mem_wr_req); end
      pop_exp(e, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_sb_empty actual=0 required=1"); end
      checks++; if (mem_wdata !== 8'h09 || mem_wdata !== e.data) begin failures++; $display("FAIL basic_data actual=%h required=%h", mem_wdata, e.data); end
      checks++; if (Z_flag !== 1'b0 || mem_addr !== 16'd0) begin failures++; $display("FAIL basic_z_addr actual=%b/%0d required=0/0", Z_flag, mem_addr); end
      mem_wr_ack = 1'b1;
      step();
      mem_wr_ack = 1'b0;
      checks++; if (mem_wr_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop actual=%b required=0", mem_wr_req); end
      checks++; if (mem_addr !== ADDR_W'(model_addr)) begin failures++; $display("FAIL basic_addr_inc actual=%0d required=%0d", mem_addr, model_addr); end
      $display("txn basic addr=%0d data=%h z=%b", e.addr, mem_wdata, Z_flag);
   endtask

   task automatic test_clamp();
      logic [31:0] vals [2];
      exp_t e;
      bit ok;
      vals[0] = 32'hFFFF_FFE0;
      vals[1] = 32'd1000;
      for (int k = 0; k < 2; k++) begin
         fill_const(vals[k]);
         push_expected();
         drive_taps(TAPS);
         wait_req(ok);
         checks++; if (!ok) begin failures++; $display("FAIL clamp%0d_req_timeout actual=0 required=1", k); end
         pop_exp(e, ok);
         checks++; if (mem_wdata !== e.data || Z_flag !== e.z) begin failures++; $display("FAIL clamp%0d_data actual=%h/%b required=%h/%b", k, mem_wdata, Z_flag, e.data, e.z); end
         checks++; if (mem_addr !== e.addr) begin failures++; $display("FAIL clamp%0d_addr actual=%0d required=%0d", k, mem_addr, e.addr); end
         $display("txn clamp tap=%h addr=%0d data=%h z=%b", vals[k], mem_addr, mem_wdata, Z_flag);
         mem_wr_ack = 1'b1;
         step();
         mem_wr_ack = 1'b0;
      end
   endtask

   task automatic test_ack_wait();
      exp_t e;
      bit ok;
      fill_random();
      push_expected();
      drive_taps(TAPS);
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ackwait_req_timeout actual=0 required=1"); end
      pop_exp(e, ok);
      alu_valid = 1'b1;
      C_bus     = 32'h7FFF_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (mem_wr_req !== 1'b1 || alu_ready !== 1'b0) begin failures++; $display("FAIL ackwait_hold%0d actual=req%b/rdy%b required=req1/rdy0", i, mem_wr_req, alu_ready); end
         checks++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin failures++; $display("FAIL ackwait_stable%0d actual=%0d/%h required=%0d/%h", i, mem_addr, mem_wdata, e.addr, e.data); end
      end
      alu_valid  = 1'b0;
      C_bus      = 32'h0;
      mem_wr_ack = 1'b1;
      step();
      mem_wr_ack = 1'b0;
      checks++; if (mem_wr_req !== 1'b0 || mem_addr !== ADDR_W'(model_addr)) begin failures++; $display("FAIL ackwait_release actual=req%b/addr%0d required=req0/addr%0d", mem_wr_req, mem_addr, model_addr); end
      checks++; if (frame_done !== e.last) begin failures++; $display("FAIL ackwait_frame_done actual=%b required=%b", frame_done, e.last); end
      step();
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL ackwait_done_pulse actual=%b required=0", frame_done); end
      $display("txn ackwait addr=%0d data=%h", e.addr, e.data);
   endtask

   task automatic test_frame();
      exp_t e;
      bit ok;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      exp_q.delete();
      model_addr = 0;
      checks++; if (mem_addr !== '0 || alu_ready !== 1'b1) begin failures++; $display("FAIL frame_restart actual=%0d/%b required=0/1", mem_addr, alu_ready); end
      for (int p = 0; p < NUM_PIXELS + 1; p++) begin
         fill_random();
         push_expected();
         drive_taps(TAPS);
         wait_req(ok);
         checks++; if (!ok) begin failures++; $display("FAIL frame%0d_req_timeout actual=0 required=1", p); end
         pop_exp(e, ok);
         checks++; if (mem_addr !== e.addr || mem_wdata !== e.data || Z_flag !== e.z) begin failures++; $display("FAIL frame%0d_write actual=%0d/%h/%b required=%0d/%h/%b", p, mem_addr, mem_wdata, Z_flag, e.addr, e.data, e.z); end
         mem_wr_ack = 1'b1;
         step();
         mem_wr_ack = 1'b0;
         checks++; if (frame_done !== e.last) begin failures++; $display("FAIL frame%0d_done actual=%b required=%b", p, frame_done, e.last); end
         $display("txn frame addr=%0d data=%h done=%b", e.addr, e.data, frame_done);
      end
      step();
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL frame_done_pulse actual=%b required=0", frame_done); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit ok;
      int dly;
      for (int p = 0; p < 2; p++) begin
         fill_random();
         push_expected();
         drive_taps(TAPS);
         wait_req(ok);
         checks++; if (!ok) begin failures++; $display("FAIL b2b%0d_req_timeout actual=0 required=1", p); end
         pop_exp(e, ok);
         dly = int'($urandom_range(0, 3));
         for (int i = 0; i < dly; i++) step();
         checks++; if (mem_addr !== e.addr || mem_wdata !== e.data || Z_flag !== e.z) begin failures++; $display("FAIL b2b%0d_write actual=%0d/%h/%b required=%0d/%h/%b", p, mem_addr, mem_wdata, Z_flag, e.addr, e.data, e.z); end
         mem_wr_ack = 1'b1;
         step();
         mem_wr_ack = 1'b0;
         $display("txn b2b addr=%0d data=%h delay=%0d", e.addr, e.data, dly);
      end
   endtask

   task automatic test_frame_start();
      exp_t e;
      bit ok;
      fill_const(32'd500);
      drive_taps(5);
      frame_start = 1'b1;
      alu_valid   = 1'b1;
      C_bus       = 32'd12345;
      step();
      frame_start = 1'b0;
      alu_valid   = 1'b0;
      C_bus       = 32'h0;
      exp_q.delete();
      model_addr = 0;
      checks++; if (mem_addr !== '0 || mem_wr_req !== 1'b0) begin failures++; $display("FAIL fstart_restart actual=%0d/%b required=0/0", mem_addr, mem_wr_req); end
      fill_random();
      push_expected();
      drive_taps(TAPS);
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL fstart_req_timeout actual=0 required=1"); end
      pop_exp(e, ok);
      checks++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin failures++; $display("FAIL fstart_write actual=%0d/%h required=%0d/%h", mem_addr, mem_wdata, e.addr, e.data); end
      mem_wr_ack = 1'b1;
      step();
      mem_wr_ack = 1'b0;
      $display("txn fstart addr=%0d data=%h", e.addr, e.data);
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      fill_random();
      push_expected();
      drive_taps(TAPS);
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_req_timeout actual=0 required=1"); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      model_addr = 0;
      checks++; if (mem_wr_req !== 1'b0 || mem_addr !== '0 || alu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state actual=%b/%0d/%b required=0/0/1", mem_wr_req, mem_addr, alu_ready); end
      $display("txn reset_mid_write req=%b", mem_wr_req);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_ack_wait();
      test_frame();
      test_back_to_back();
      test_frame_start();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
